karatsuba_reduce: RTL and testbench

Downstream consumer of the 3-product Karatsuba multiplier stage. Takes the H0/L0/M0 partial products for a 255x255-bit multiply. Recombines them into the 510-bit product and reduces it modulo p = 2^255 - RED_C (Curve25519 field, RED_C = 19). One operation in flight; valid/ready handshake on both sides; fixed 4-edge compute latency.

---
 rtl/karatsuba_reduce_pkg.sv | 34 +++
 rtl/karatsuba_reduce_red_fold.sv | 30 +++
 rtl/karatsuba_reduce.sv | 140 ++++++++++++++
 tb/tb_karatsuba_reduce.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_reduce_pkg.sv
// Shared widths, field constants and FSM encoding for the Karatsuba
// recombine-and-reduce stage (Curve25519 field, p = 2^255 - RED_C).
package karatsuba_reduce_pkg;

  localparam int W_OP   = 255;
  localparam int W_H    = 254;
  localparam int W_L    = 256;
  localparam int W_M    = 258;
  localparam int W_PROD = 510;
  localparam int W_T1   = 260;
  localparam int W_T2   = 256;

  // Half-width of the Karatsuba split: X = A2*2^SPLIT + A1.
  localparam int SPLIT = 128;

  localparam int RED_C_DEF = 19;

  // 2^W_OP - c written as all-ones minus (c - 1), avoiding a W_OP+1 bit constant.
  function automatic logic [W_OP-1:0] p_of(input int red_c);
    return {W_OP{1'b1}} - W_OP'(red_c - 1);
  endfunction

  localparam logic [W_OP-1:0] P_MOD = p_of(RED_C_DEF);

  typedef enum logic [2:0] {
    IDLE,
    COMB,
    FOLD1,
    FOLD2,
    FIN,
    OUT
  } state_t;

endpackage

// File: rtl/karatsuba_reduce_red_fold.sv
// Combinational fold step: sum = lo + RED_C * hi, with the constant
// multiply expanded into shifted adds of hi for each set bit of RED_C.
module karatsuba_reduce_red_fold #(
  parameter int W_LO  = 255,
  parameter int W_HI  = 255,
  parameter int W_OUT = 260,
  parameter int RED_C = 19
) (
  input  logic [W_LO-1:0]  lo,
  input  logic [W_HI-1:0]  hi,
  output logic [W_OUT-1:0] sum
);

  localparam logic [4:0] C_BITS = 5'(RED_C);

  logic [W_OUT-1:0] hi_ext;

  // NOTE: blocking '=' is right here -- this is combinational and the loop
  // accumulates into sum within one evaluation; registers elsewhere use '<='.
  always_comb begin
    hi_ext = W_OUT'(hi);
    sum    = W_OUT'(lo);
    for (int k = 0; k < 5; k++) begin
      if (C_BITS[k]) begin
        sum = sum + (hi_ext << k);
      end
    end
  end

endmodule

// File: rtl/karatsuba_reduce.sv
// Recombines Karatsuba partial products H0/L0/M0 into the 510-bit product and
// reduces it modulo 2^255 - RED_C; one op in flight, fixed 4-edge latency.
module karatsuba_reduce
  import karatsuba_reduce_pkg::*;
#(
  parameter int RED_C = RED_C_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_H-1:0]  H0,
  input  logic [W_L-1:0]  L0,
  input  logic [W_M-1:0]  M0,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W_OP-1:0] R
);

  localparam logic [W_OP-1:0] P_LOC = p_of(RED_C);

  state_t state, state_nx;

  logic [W_H-1:0]    h_q;
  logic [W_L-1:0]    l_q;
  logic [W_M-1:0]    m_q;
  logic [W_PROD-1:0] p_q;
  logic [W_T1-1:0]   t1_q;
  logic [W_T2-1:0]   t2_q;
  logic [W_OP-1:0]   r_q;

  logic [W_M-1:0]    mid;
  logic [W_PROD-1:0] prod;
  logic [W_T1-1:0]   t1_d;
  logic [W_T2-1:0]   t2_d;
  logic              t2_ge_p;
  logic [W_OP-1:0]   r_d;
  logic              accept;

  assign accept = in_valid && in_ready;
  assign R      = r_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- an unassigned path would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = COMB;
      COMB:                   state_nx = FOLD1;
      FOLD1:                  state_nx = FOLD2;
      FOLD2:                  state_nx = FIN;
      FIN:                    state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
  end

  // ---------------------------------------------------------- datapath
  // mid < 2^257 for legal inputs; the product's 511th bit is always zero, so
  // building it at 510 bits (wrapping) yields exactly the low 510 bits.
  always_comb begin
    mid  = m_q - W_M'(h_q) - W_M'(l_q);
    prod = (W_PROD'(h_q) << (2 * SPLIT))
         + (W_PROD'(mid) << SPLIT)
         + W_PROD'(l_q);
  end

  karatsuba_reduce_red_fold #(
    .W_LO (W_OP),
    .W_HI (W_PROD - W_OP),
    .W_OUT(W_T1),
    .RED_C(RED_C)
  ) u_fold1 (
    .lo (p_q[W_OP-1:0]),
    .hi (p_q[W_PROD-1:W_OP]),
    .sum(t1_d)
  );

  karatsuba_reduce_red_fold #(
    .W_LO (W_OP),
    .W_HI (W_T1 - W_OP),
    .W_OUT(W_T2),
    .RED_C(RED_C)
  ) u_fold2 (
    .lo (t1_q[W_OP-1:0]),
    .hi (t1_q[W_T1-1:W_OP]),
    .sum(t2_d)
  );

  // T2 < 2p, so one conditional subtract lands in [0, p); when taken the
  // difference fits in W_OP bits, so the subtract is done at that width.
  always_comb begin
    t2_ge_p = (t2_q >= {1'b0, P_LOC});
    r_d     = t2_ge_p ? (t2_q[W_OP-1:0] - P_LOC) : t2_q[W_OP-1:0];
  end

  // NOTE: all datapath registers are cleared on reset so an aborted op leaves
  // no stale product and R reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_q  <= '0;
      l_q  <= '0;
      m_q  <= '0;
      p_q  <= '0;
      t1_q <= '0;
      t2_q <= '0;
      r_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            h_q <= H0;
            l_q <= L0;
            m_q <= M0;
          end
        end
        COMB:    p_q  <= prod;
        FOLD1:   t1_q <= t1_d;
        FOLD2:   t2_q <= t2_d;
        FIN:     r_q  <= r_d;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_reduce.sv
// Self-checking bench for karatsuba_reduce: directed corner cases plus random
// operands, compared against plain modular arithmetic on the full product.
module tb_karatsuba_reduce;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [253:0] H0;
  logic [255:0] L0;
  logic [257:0] M0;
  logic         out_valid;
  logic         out_ready;
  logic [254:0] R;

  int total;
  int passed;

  logic [255:0] one256;
  logic [254:0] p_val;

  karatsuba_reduce dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .H0       (H0),
    .L0       (L0),
    .M0       (M0),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .R        (R)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: true product reduced with the modulo operator.
  function automatic logic [254:0] gold(input logic [254:0] x, input logic [254:0] y);
    logic [509:0] pr;
    pr = 510'(x) * 510'(y);
    return 255'(pr % 510'(p_val));
  endfunction

  // Karatsuba partials of X*Y as the upstream multiplier would deliver them.
  task automatic split(input logic [254:0] x, input logic [254:0] y,
                       output logic [253:0] h, output logic [255:0] l,
                       output logic [257:0] m);
    logic [127:0] a1, b1;
    logic [126:0] a2, b2;
    a1 = x[127:0];
    a2 = x[254:128];
    b1 = y[127:0];
    b2 = y[254:128];
    h = 254'(a2) * 254'(b2);
    l = 256'(a1) * 256'(b1);
    m = 258'(129'(a1) + 129'(a2)) * 258'(129'(b1) + 129'(b2));
  endtask

  function automatic logic [254:0] rand255();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v[254:0];
  endfunction

  // Presents X*Y partials and returns just after the accept edge.
  task automatic start_op(input logic [254:0] x, input logic [254:0] y);
    logic [253:0] h;
    logic [255:0] l;
    logic [257:0] m;
    int n;
    split(x, y, h, l, m);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("issue_wait_timeout", 256'(in_ready), 256'(1));
    in_valid = 1'b1;
    H0 = h;
    L0 = l;
    M0 = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic run_full(input string tag, input logic [254:0] x, input logic [254:0] y);
    int lat;
    start_op(x, y);
    wait_result(lat);
    check({tag, "_latency"}, 256'(lat), 256'(4));
    check(tag, 256'(R), 256'(gold(x, y)));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    logic [254:0] exp_r;
    logic [254:0] x;

    total     = 0;
    passed    = 0;
    one256    = 256'd1;
    p_val     = 255'((one256 << 255) - 256'd19);
    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    H0        = '1;
    L0        = '1;
    M0        = '1;

    // Reset held for two edges with junk on the inputs.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_r", 256'(R), 256'(0));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 256'(in_ready), 256'(1));
    check("post_rst_out_valid", 256'(out_valid), 256'(0));

    // Directed values.
    run_full("small_2x3", 255'd2, 255'd3);
    check("small_const", 256'(R), 256'd6);
    run_full("fold_2p254x2", 255'(one256 << 254), 255'd2);
    check("fold_const", 256'(R), 256'd19);
    run_full("wrap_pm1_sq", p_val - 255'd1, p_val - 255'd1);
    check("wrap_const", 256'(R), 256'd1);
    run_full("p_times_1", p_val, 255'd1);
    check("p_const", 256'(R), 256'd0);
    run_full("p1_times_1", p_val + 255'd1, 255'd1);
    check("p1_const", 256'(R), 256'd1);

    // Backpressure with in_valid pulses while the result waits.
    x = rand255();
    exp_r = gold(x, 255'd12345);
    start_op(x, 255'd12345);
    wait_result(lat);
    check("bp_latency", 256'(lat), 256'(4));
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      H0 = 254'(rand255());
      L0 = 256'(rand255());
      M0 = 258'(rand255());
      @(posedge clk); #1;
      check("bp_r_stable", 256'(R), 256'(exp_r));
      check("bp_out_valid", 256'(out_valid), 256'(1));
      check("bp_in_ready", 256'(in_ready), 256'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 256'(in_ready), 256'(1));
    check("bp_release_out_valid", 256'(out_valid), 256'(0));
    check("bp_release_r_kept", 256'(R), 256'(exp_r));
    @(posedge clk); #1;
    check("bp_pulse_not_latched", 256'(in_ready), 256'(1));

    // Reset while the op sits in FOLD1.
    start_op(255'd5, 255'd7);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", 256'(in_ready), 256'(1));
    check("midrst_out_valid", 256'(out_valid), 256'(0));
    check("midrst_r", 256'(R), 256'(0));
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", 256'(seen), 256'(0));

    // Random operands, back to back.
    for (int i = 0; i < 1000; i++) begin
      run_full("random", rand255(), rand255());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
